// File: rtl/dfe_pkg.sv
// Shared DFE constants and helpers.
// Interpolation factor limits and factor decoding.
package dfe_pkg;

  localparam int MAX_INT_FACTOR = 16;
  localparam int INT_WIDTH = $clog2(MAX_INT_FACTOR);
  localparam int LOG_WIDTH = $clog2(INT_WIDTH + 1);

  function automatic logic [LOG_WIDTH-1:0] int_log2(
    input logic [INT_WIDTH:0] f
  );
    logic [LOG_WIDTH-1:0] lg;
    lg = '0;
    for (int b = 1; b <= INT_WIDTH; b++) begin
      if (f >= (INT_WIDTH+1)'(1 << b)) begin
        lg = LOG_WIDTH'(b);
      end
    end
    return lg;
  endfunction

endpackage

// File: rtl/cic_interp_ctrl.sv
// CIC interpolator burst control.
// Phase counter, handshake, config latch, change detect.
module cic_interp_ctrl
  import dfe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 bypass,
  input  logic [INT_WIDTH:0]   int_factor,
  input  logic                 valid_out,
  input  logic                 ready_out,
  output logic                 ready_in,
  output logic                 accept,
  output logic                 step,
  output logic                 clear,
  output logic [LOG_WIDTH-1:0] shift_lg
);

  logic [INT_WIDTH:0]   rem;
  logic [INT_WIDTH:0]   r_eff;
  logic [LOG_WIDTH-1:0] lg_q;
  logic [LOG_WIDTH-1:0] lg_new;
  logic                 byp_q;
  logic                 advance;

  assign advance  = ~valid_out | ready_out;
  assign ready_in = ~rst & (rem == '0) & advance;
  assign accept   = valid_in & ready_in;
  assign step     = (accept | (rem != '0)) & advance;

  assign lg_new = bypass ? '0 : int_log2(int_factor);
  assign r_eff  = (INT_WIDTH+1)'(1) << lg_new;

  // A bypass burst or a new factor invalidates filter history
  assign clear    = accept & ~bypass & (byp_q | (lg_new != lg_q));
  assign shift_lg = accept ? lg_new : lg_q;

  // Remaining zero phases and latched burst config
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      lg_q  <= '0;
      byp_q <= 1'b0;
    end else if (accept) begin
      rem   <= r_eff - (INT_WIDTH+1)'(1);
      lg_q  <= lg_new;
      byp_q <= bypass;
    end else if (step) begin
      rem <= rem - (INT_WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator, power-of-two factor.
// Comb at input rate, zero-stuff, integrate, normalise.
module cic_interpolator
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_FRAC  = 15,
  parameter int N          = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic signed [DATA_WIDTH-1:0] cic_in,
  input  logic                         bypass,
  input  logic [INT_WIDTH:0]           int_factor,
  output logic signed [DATA_WIDTH-1:0] cic_out,
  output logic                         valid_out,
  input  logic                         ready_out
);

  localparam int ACC_WIDTH = DATA_WIDTH + N * INT_WIDTH;

  if (N < 1 || N > 4 || DATA_FRAC >= DATA_WIDTH) begin : g_bad_cfg
    $error("cic_interpolator: illegal parameters");
  end

  logic                 accept;
  logic                 step;
  logic                 clear;
  logic [LOG_WIDTH-1:0] shift_lg;
  logic [4:0]           sh_amt;
  logic                 comb_en;
  logic                 int_en;

  logic signed [ACC_WIDTH-1:0] dly_v   [N];
  logic signed [ACC_WIDTH-1:0] acc_v   [N];
  logic signed [ACC_WIDTH-1:0] comb_v  [N+1];
  logic signed [ACC_WIDTH-1:0] integ_v [N+1];

  cic_interp_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .bypass     (bypass),
    .int_factor (int_factor),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .ready_in   (ready_in),
    .accept     (accept),
    .step       (step),
    .clear      (clear),
    .shift_lg   (shift_lg)
  );

  assign comb_en = accept & ~bypass;
  assign int_en  = step & ~(accept & bypass);
  assign sh_amt  = 5'(N - 1) * 5'(shift_lg);

  // Comb chain and integrator chain on post-update values
  always_comb begin
    comb_v[0] = ACC_WIDTH'(cic_in);
    for (int k = 0; k < N; k++) begin
      comb_v[k+1] = comb_v[k] - (clear ? '0 : dly_v[k]);
    end
    integ_v[0] = accept ? comb_v[N] : '0;
    for (int k = 0; k < N; k++) begin
      integ_v[k+1] = integ_v[k] + (clear ? '0 : acc_v[k]);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic signed [ACC_WIDTH-1:0] dly_q;
    logic signed [ACC_WIDTH-1:0] acc_q;

    assign dly_v[k] = dly_q;
    assign acc_v[k] = acc_q;

    // Comb delay advances once per filtered input
    always_ff @(posedge clk) begin
      if (rst) begin
        dly_q <= '0;
      end else if (comb_en) begin
        dly_q <= comb_v[k];
      end
    end

    // Integrator advances once per output phase
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else if (int_en) begin
        acc_q <= integ_v[k+1];
      end
    end
  end

  // Registered output: bypass sample or normalised integrator
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      cic_out   <= '0;
    end else if (step) begin
      valid_out <= 1'b1;
      cic_out   <= (accept & bypass)
                 ? cic_in
                 : DATA_WIDTH'(integ_v[N] >>> sh_amt);
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator, N=1 and N=2 in lockstep.
// B-spline reference model with history segments.
module tb_cic_interpolator;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] cic_in;
  logic        bypass;
  logic [4:0]  int_factor;
  logic        ready_out;

  logic        ready_in1;
  logic        ready_in2;
  logic        valid_out1;
  logic        valid_out2;
  logic [15:0] cic_out1;
  logic [15:0] cic_out2;

  int tests;
  int fails;

  longint hist[$];
  int     prev_r;
  bit     prev_byp;

  cic_interpolator #(.N(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_in   (ready_in1),
    .cic_in     (cic_in),
    .bypass     (bypass),
    .int_factor (int_factor),
    .cic_out    (cic_out1),
    .valid_out  (valid_out1),
    .ready_out  (ready_out)
  );

  cic_interpolator #(.N(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_in   (ready_in2),
    .cic_in     (cic_in),
    .bypass     (bypass),
    .int_factor (int_factor),
    .cic_out    (cic_out2),
    .valid_out  (valid_out2),
    .ready_out  (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Output of an N-stage CIC: inputs since last clear convolved
  // with the N-fold boxcar of length r, divided by r^(N-1), floored.
  function automatic longint model(int n, int r, int lg, int p);
    longint h[64];
    longint t[64];
    longint y;
    int     len;
    int     last;
    int     idx;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < n; s++) begin
      foreach (t[i]) t[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < r; j++)
          t[i+j] += h[i];
      len += r - 1;
      h = t;
    end
    y = 0;
    last = hist.size() - 1;
    for (int i = 0; i <= last; i++) begin
      idx = (last - i) * r + p;
      if (idx < len) y += hist[i] * h[idx];
    end
    return y >>> ((n - 1) * lg);
  endfunction

  task automatic idle();
    @(posedge clk);
    #1;
    check("idle_valid1", 16'(valid_out1), 16'd0);
    check("idle_valid2", 16'(valid_out2), 16'd0);
  endtask

  task automatic send(
    input logic [15:0] x,
    input int          f,
    input bit          byp,
    input int          stall_at,
    input int          rst_at
  );
    int     r;
    int     lg;
    bit     ok;
    longint q1;
    longint q2;
    r  = 1;
    lg = 0;
    if (!byp) begin
      while (r < 16 && r * 2 <= f) begin
        r  = r * 2;
        lg = lg + 1;
      end
    end
    valid_in   = 1'b1;
    cic_in     = x;
    int_factor = 5'(f);
    bypass     = byp;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_in1 && ready_in2) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_wait", 16'(ok), 16'd1);
    if (!ok) begin
      valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (!byp) begin
      if (prev_byp || r != prev_r) hist.delete();
      hist.push_back(longint'($signed(x)));
    end
    prev_r   = r;
    prev_byp = byp;
    for (int p = 0; p < r; p++) begin
      if (byp) begin
        q1 = longint'($signed(x));
        q2 = q1;
      end else begin
        q1 = model(1, r, lg, p);
        q2 = model(2, r, lg, p);
      end
      check("fits1", 16'(q1 >= -32768 && q1 <= 32767), 16'd1);
      check("fits2", 16'(q2 >= -32768 && q2 <= 32767), 16'd1);
      check("out1", cic_out1, q1[15:0]);
      check("out2", cic_out2, q2[15:0]);
      check("valid1", 16'(valid_out1), 16'd1);
      check("valid2", 16'(valid_out2), 16'd1);
      check("rdy_phase", 16'(ready_in1 & ready_in2), 16'(p == r - 1));
      if (p == rst_at) begin
        rst = 1'b1;
        #1;
        check("rdy_in_rst", 16'(ready_in1 | ready_in2), 16'd0);
        @(posedge clk);
        #1;
        check("rst_valid1", 16'(valid_out1), 16'd0);
        check("rst_valid2", 16'(valid_out2), 16'd0);
        check("rst_out1", cic_out1, 16'h0000);
        check("rst_out2", cic_out2, 16'h0000);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 16'(ready_in1 & ready_in2), 16'd1);
        hist.delete();
        prev_r   = 1;
        prev_byp = 1'b0;
        return;
      end
      if (p == stall_at) begin
        ready_out = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          check("stall_out1", cic_out1, q1[15:0]);
          check("stall_out2", cic_out2, q2[15:0]);
          check("stall_valid", 16'(valid_out1 & valid_out2), 16'd1);
          check("stall_rdy", 16'(ready_in1 | ready_in2), 16'd0);
        end
        ready_out = 1'b1;
      end
      if (p < r - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    prev_r     = 1;
    prev_byp   = 1'b0;
    rst        = 1'b1;
    valid_in   = 1'b0;
    cic_in     = '0;
    bypass     = 1'b0;
    int_factor = '0;
    ready_out  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid1", 16'(valid_out1), 16'd0);
    check("rst_valid2", 16'(valid_out2), 16'd0);
    check("rst_cic1", cic_out1, 16'h0000);
    check("rst_cic2", cic_out2, 16'h0000);
    check("rst_rdy", 16'(ready_in1 | ready_in2), 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 16'(ready_in1 & ready_in2), 16'd1);

    send(16'h4000, 4, 1'b0, -1, -1);
    send(16'h0000, 4, 1'b0, -1, -1);
    idle();

    send(16'h2000, 2, 1'b0, -1, -1);
    send(16'h0000, 2, 1'b0, -1, -1);
    send(16'h0000, 2, 1'b0, -1, -1);
    idle();

    send(16'h2000, 5, 1'b0, -1, -1);
    send(16'h2000, 5, 1'b0, 1, -1);
    send(16'h2000, 5, 1'b0, -1, -1);
    send(16'h2000, 5, 1'b0, 3, -1);
    idle();

    send(16'h1234, 4, 1'b0, -1, -1);
    send(16'hF800, 4, 1'b0, -1, -1);
    send(16'h2000, 2, 1'b0, -1, -1);
    send(16'h0000, 2, 1'b0, -1, -1);

    send(16'h7FFF, 8, 1'b1, -1, -1);
    send(16'h8000, 3, 1'b1, -1, -1);
    send(16'h1000, 1, 1'b0, -1, -1);
    send(16'h1000, 0, 1'b0, -1, -1);
    send(16'h7FFF, 31, 1'b0, -1, -1);
    send(16'h8000, 16, 1'b0, -1, -1);
    idle();

    send(16'h3000, 8, 1'b0, -1, 2);
    send(16'h2000, 2, 1'b0, -1, -1);
    send(16'h0000, 2, 1'b0, -1, -1);
    idle();

    for (int i = 0; i < 40; i++) begin
      send(16'($urandom),
           int'($urandom_range(0, 31)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
           -1);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Transmit-direction counterpart of the receive decimation chain's CIC. Accepts samples at the low (baseband) rate over a valid/ready handshake and emits R interpolated samples per input, where R is a runtime power-of-two factor in 1..16, through an N-stage comb → zero-stuff → integrator CIC. The block sits at the head of the DUC path, feeding the upsampling filters. Output gain is exactly normalised, so the output always fits in DATA_WIDTH.

## Interface
- DATA_WIDTH, 16: sample width, signed Q(DATA_WIDTH-DATA_FRAC).DATA_FRAC.
- DATA_FRAC, 15: fractional bits; pass-through only, no arithmetic effect.
- N, 1: number of comb and integrator stages, legal range 1..4.
- MAX_INT_FACTOR, 16: largest interpolation factor (localparam).
- INT_WIDTH, $clog2(MAX_INT_FACTOR): localparam.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  cic_in is valid.
- ready_in  out  1  block accepts cic_in this cycle.
- cic_in  in  DATA_WIDTH  signed input sample.
- bypass  in  1  pass input straight to output with R forced to 1.
- int_factor  in  INT_WIDTH+1  requested interpolation factor.
- cic_out  out  DATA_WIDTH  signed output sample.
- valid_out  out  1  cic_out is valid.
- ready_out  in  1  downstream accepts cic_out.

## Operation
- accept = valid_in & ready_in. step = (accept | rem != 0) & (!valid_out | ready_out).
- ready_in = !rst & (rem == 0) & (!valid_out | ready_out). An accept therefore always implies a step.
- Configuration is latched on accept. R_eff is the largest power of two ≤ int_factor; 0 is treated as 1, and values ≥ 16 give 16. bypass forces R_eff = 1.
- Burst states:
  - IDLE (rem = 0).
  - RUN (rem = 1..R_eff-1): one step per zero phase.
  - Accept loads rem <= R_eff-1. Each non-accept step decrements rem.
- Comb section, input rate:
  - N stages, differential delay 1: c_k = c_{k-1} - z^-1(c_{k-1}).
  - Comb state updates only on accept.
- Integrator input is the comb output on the accept step and 0 on every other step. N integrators, all updating only on step.
- Internal width ACC_WIDTH = DATA_WIDTH + N*INT_WIDTH. All comb/integrator arithmetic is two's-complement wrap-around modulo 2^ACC_WIDTH.
- Normalisation:
  - cic_out = integrator_N >> ((N-1)*log2(R_eff)), arithmetic shift, truncation toward −∞.
  - The result is a convex (B-spline) combination of inputs and fits DATA_WIDTH with no saturation.
  - The bench asserts the discarded upper bits are a pure sign extension.
- Factor change: if the latched R_eff differs from the previous burst's R_eff, all comb and integrator state is cleared before the accept step uses it.
- Bypass accept: cic_out <= cic_in; filter state is not modified.
- Toggling bypass off clears filter state on the next non-bypass accept.
- Backpressure: while valid_out & !ready_out, nothing advances. cic_out and valid_out hold and ready_in = 0.

## Timing
- Reset values, applied on the clock edge with rst = 1:
  - valid_out = 0, cic_out = 0, rem = 0.
  - Comb and integrator state = 0; latched R_eff = 1.
  - ready_in = 0 during rst, 1 the first cycle after.
- Reset during a burst abandons the remaining phases immediately.
- Latency: an accept at edge t makes valid_out high after t, carrying phase 0.
- Each step registers the next output on that edge. cic_out is registered, computed from the post-update integrator_N.
- Throughput: with ready_out tied high, exactly 1 output per cycle and 1 input per R_eff cycles. No bubble between bursts.
- valid_out falls on the edge where the last phase is consumed and no step is taken.

## Structure
- Shared package dfe_pkg: MAX_INT_FACTOR, INT_WIDTH, and a function mapping int_factor to log2(R_eff).
- One sub-module, cic_interp_ctrl: rem counter, ready_in/step generation, config latch and change detect.
- Comb, integrator and shift datapath stay in cic_interpolator, using generate loops over N.

## Test plan
- N=1, int_factor=4, single input 0x4000 then zeros, ready_out=1 -> outputs 0x4000 ×4, then 0x0000. ready_in low for 3 cycles after the accept.
- N=2, int_factor=2, impulse 0x2000 -> outputs 0x1000, 0x2000, 0x1000, 0x0000 (linear interpolation).
- N=2, int_factor=5 (→4), constant 0x2000 input -> settles to 0x2000 every output. The first burst ramps 0x0800, 0x1000, 0x1800, 0x2000.
- Mid-burst ready_out low for 3 cycles -> cic_out and valid_out stable, ready_in=0, no phase lost. The output sequence is identical to the unstalled run.
- Change int_factor 4→2 between bursts with nonzero state -> state cleared; the output equals the fresh-start response. bypass=1 with input 0x7FFF -> 0x7FFF on the next cycle, one output per input.
- rst asserted at phase 2 of an R=8 burst -> the next cycle shows valid_out=0 and cic_out=0. A subsequent impulse gives the clean-start response.
